// File: rtl/pat_pkg.sv
// pat_pkg
// Shared definitions for the pattern processor field-side blocks.
//   BUFP_WIDTH_C   : buffer select width (matches the core's bufp)
//   FIELDP_WIDTH_C : field index width (matches the core's fieldp/fieldwp)
//   BUFFER_WIDTH_C : field data width (matches the core's field_in/field_out)
//   pat_buf_state_t: streaming FSM states
package pat_pkg;

  localparam int BUFP_WIDTH_C   = 3;
  localparam int FIELDP_WIDTH_C = 5;
  localparam int BUFFER_WIDTH_C = 8;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } pat_buf_state_t;

endpackage

// File: rtl/pat_buf_stream_ctrl.sv
// pat_buf_stream_ctrl
// Streaming controller for the field buffer. Owns the IDLE/STREAM FSM, the
// field counter, the latched buffer index, the valid/ready handshake and
// the blocked-write detect. The storage array lives in the parent.
// Build option: PATBUF_AUTOCLEAR_EN -- when defined, clear_en strobes on
// every accepted beat so the parent zeroes the streamed word.
// Ports:
//   clk, reset        clock, asynchronous active-high reset
//   commit, bufp      stream request and the core's buffer select
//   field_wr_en       core write request (for blocked-write detect)
//   stream_ready      sink handshake
//   busy, stream_valid, stream_last, stream_done, stream_buf  stream status
//   wr_blocked        one-cycle pulse after a dropped write
//   wr_allow          qualified write enable for the storage array
//   clear_en          zero the word at {stream_buf, beat_idx}
//   beat_idx          field index of the current beat
module pat_buf_stream_ctrl
  import pat_pkg::*;
#(
  parameter int BUFP_WIDTH   = BUFP_WIDTH_C,
  parameter int FIELDP_WIDTH = FIELDP_WIDTH_C
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    commit,
  input  logic [BUFP_WIDTH-1:0]   bufp,
  input  logic                    field_wr_en,
  input  logic                    stream_ready,
  output logic                    busy,
  output logic                    stream_valid,
  output logic                    stream_last,
  output logic                    stream_done,
  output logic [BUFP_WIDTH-1:0]   stream_buf,
  output logic                    wr_blocked,
  output logic                    wr_allow,
  output logic                    clear_en,
  output logic [FIELDP_WIDTH-1:0] beat_idx
);

  pat_buf_state_t          state_reg;
  logic [FIELDP_WIDTH-1:0] cnt_reg;
  logic [BUFP_WIDTH-1:0]   cur_buf_reg;
  logic                    done_reg;
  logic                    blocked_reg;

  logic beat_accept;
  logic block_hit;

  assign busy         = (state_reg == STREAM);
  assign stream_valid = busy;
  assign stream_last  = busy && (cnt_reg == '1);
  assign stream_done  = done_reg;
  assign stream_buf   = cur_buf_reg;
  assign wr_blocked   = blocked_reg;
  assign beat_idx     = cnt_reg;
  assign beat_accept  = busy && stream_ready;

  // A core write into the buffer currently being streamed would corrupt
  // the beat sequence, so it is dropped.
  assign block_hit = field_wr_en && busy && (bufp == cur_buf_reg);
  assign wr_allow  = field_wr_en && !block_hit;

`ifdef PATBUF_AUTOCLEAR_EN
  assign clear_en = beat_accept;
`else
  assign clear_en = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      cur_buf_reg <= '0;
      done_reg    <= 1'b0;
      blocked_reg <= 1'b0;
    end else begin
      done_reg    <= 1'b0;
      blocked_reg <= block_hit;
      case (state_reg)
        IDLE: begin
          if (commit) begin
            state_reg   <= STREAM;
            cur_buf_reg <= bufp;
            cnt_reg     <= '0;
          end
        end
        STREAM: begin
          // commit is ignored here; the core polls busy
          if (beat_accept) begin
            cnt_reg <= cnt_reg + 1'b1;  // wraps to 0 only on the last beat
            if (cnt_reg == '1) begin
              state_reg <= IDLE;
              done_reg  <= 1'b1;
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/pat_field_buffer.sv
// pat_field_buffer
// Field buffer memory beside the pattern processor core. The core reads
// field_rdata = mem[bufp][fieldp] combinationally and writes mem[bufp][fieldwp]
// on posedge. A commit streams a whole buffer, field by field, over a
// valid/ready port. Memory clears on reset, so it is built from registers.
// Build option: PATBUF_AUTOCLEAR_EN -- streamed words are zeroed as they
// are accepted (handled in pat_buf_stream_ctrl via clear_en).
// Ports:
//   clk, reset                          clock, asynchronous active-high reset
//   bufp, fieldp, fieldwp               core buffer / read / write indices
//   field_wr_en, field_wdata            core write port
//   field_rdata                         core read port (no write bypass)
//   commit, busy, wr_blocked            stream request and status
//   stream_valid/ready/data/last/buf    stream beat
//   stream_done                         pulse after the last beat
module pat_field_buffer
  import pat_pkg::*;
#(
  parameter int BUFP_WIDTH   = BUFP_WIDTH_C,
  parameter int FIELDP_WIDTH = FIELDP_WIDTH_C,
  parameter int BUFFER_WIDTH = BUFFER_WIDTH_C
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [BUFP_WIDTH-1:0]   bufp,
  input  logic [FIELDP_WIDTH-1:0] fieldp,
  input  logic [FIELDP_WIDTH-1:0] fieldwp,
  input  logic                    field_wr_en,
  input  logic [BUFFER_WIDTH-1:0] field_wdata,
  output logic [BUFFER_WIDTH-1:0] field_rdata,
  input  logic                    commit,
  output logic                    busy,
  output logic                    wr_blocked,
  output logic                    stream_valid,
  input  logic                    stream_ready,
  output logic [BUFFER_WIDTH-1:0] stream_data,
  output logic                    stream_last,
  output logic [BUFP_WIDTH-1:0]   stream_buf,
  output logic                    stream_done
);

  localparam int ADDR_W = BUFP_WIDTH + FIELDP_WIDTH;
  localparam int DEPTH  = 2 ** ADDR_W;

  logic [BUFFER_WIDTH-1:0] mem [DEPTH];

  logic                    wr_allow;
  logic                    clear_en;
  logic [FIELDP_WIDTH-1:0] beat_idx;
  logic [ADDR_W-1:0]       stream_addr;

  pat_buf_stream_ctrl #(
    .BUFP_WIDTH  (BUFP_WIDTH),
    .FIELDP_WIDTH(FIELDP_WIDTH)
  ) u_ctrl (
    .clk         (clk),
    .reset       (reset),
    .commit      (commit),
    .bufp        (bufp),
    .field_wr_en (field_wr_en),
    .stream_ready(stream_ready),
    .busy        (busy),
    .stream_valid(stream_valid),
    .stream_last (stream_last),
    .stream_done (stream_done),
    .stream_buf  (stream_buf),
    .wr_blocked  (wr_blocked),
    .wr_allow    (wr_allow),
    .clear_en    (clear_en),
    .beat_idx    (beat_idx)
  );

  assign stream_addr = {stream_buf, beat_idx};
  assign field_rdata = mem[{bufp, fieldp}];
  assign stream_data = busy ? mem[stream_addr] : '0;

  // Core write and auto-clear never hit the same word: a core write into
  // the streamed buffer is already dropped by wr_allow.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (wr_allow) begin
        mem[{bufp, fieldwp}] <= field_wdata;
      end
      if (clear_en) begin
        mem[stream_addr] <= '0;
      end
    end
  end

endmodule

// File: tb/tb_pat_field_buffer.sv
// tb_pat_field_buffer
// Directed bench for pat_field_buffer: core read/write port, full-rate and
// stalled streaming, blocked writes, mid-stream commit, reset abort and
// the optional auto-clear behaviour (PATBUF_AUTOCLEAR_EN).
module tb_pat_field_buffer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] bufp = '0;
  logic [4:0] fieldp = '0;
  logic [4:0] fieldwp = '0;
  logic       field_wr_en = 1'b0;
  logic [7:0] field_wdata = '0;
  logic [7:0] field_rdata;
  logic       commit = 1'b0;
  logic       busy;
  logic       wr_blocked;
  logic       stream_valid;
  logic       stream_ready = 1'b0;
  logic [7:0] stream_data;
  logic       stream_last;
  logic [2:0] stream_buf;
  logic       stream_done;

  int checks = 0;
  int errors = 0;

`ifdef PATBUF_AUTOCLEAR_EN
  localparam bit AUTOCLEAR = 1'b1;
`else
  localparam bit AUTOCLEAR = 1'b0;
`endif

  pat_field_buffer dut (
    .clk         (clk),
    .reset       (reset),
    .bufp        (bufp),
    .fieldp      (fieldp),
    .fieldwp     (fieldwp),
    .field_wr_en (field_wr_en),
    .field_wdata (field_wdata),
    .field_rdata (field_rdata),
    .commit      (commit),
    .busy        (busy),
    .wr_blocked  (wr_blocked),
    .stream_valid(stream_valid),
    .stream_ready(stream_ready),
    .stream_data (stream_data),
    .stream_last (stream_last),
    .stream_buf  (stream_buf),
    .stream_done (stream_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  // advance to 1 time unit after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_word(input logic [2:0] b, input logic [4:0] f, input logic [7:0] d);
    bufp = b; fieldwp = f; field_wdata = d; field_wr_en = 1'b1;
    tick();
    field_wr_en = 1'b0;
  endtask

  task automatic fill(input logic [2:0] b, input logic [7:0] base);
    for (int i = 0; i < 32; i++) begin
      write_word(b, 5'(i), base + 8'(i));
    end
  endtask

  // Streams buffer b and checks each beat against base+index (or zero).
  // toggle selects the ready pattern 1,0,0,1,0,0...
  task automatic stream_check(input logic [2:0] b, input logic [7:0] base, input bit zeros,
                              input bit toggle, input bit do_commit);
    int idx = 0;
    int cyc = 0;
    logic [7:0] exp_d;
    if (do_commit) begin
      bufp = b; commit = 1'b1; stream_ready = 1'b0;
      #1;
      check("valid_before_commit_edge", stream_valid, 0);
      tick();
      commit = 1'b0;
    end
    while (idx < 32 && cyc < 400) begin
      stream_ready = toggle ? (cyc % 3 == 0) : 1'b1;
      #1;
      exp_d = zeros ? 8'h00 : base + 8'(idx);
      check($sformatf("beat%0d_valid", idx), stream_valid, 1);
      check($sformatf("beat%0d_data", idx), stream_data, exp_d);
      check($sformatf("beat%0d_last", idx), stream_last, (idx == 31));
      check($sformatf("beat%0d_buf", idx), stream_buf, b);
      check($sformatf("beat%0d_done_low", idx), stream_done, 0);
      if (stream_ready) idx++;
      cyc++;
      tick();
    end
    stream_ready = 1'b0;
    check("accepted_beats", idx, 32);
    if (!toggle) check("full_rate_cycles", cyc, 32);
    #1;
    check("done_pulse", stream_done, 1);
    check("busy_after", busy, 0);
    check("valid_after", stream_valid, 0);
    check("idle_data_zero", stream_data, 0);
    check("idle_buf_is_cur", stream_buf, b);
    tick();
    check("done_single", stream_done, 0);
  endtask

  initial begin
    // ---- reset state ----
    #12;
    check("rst_busy", busy, 0);
    check("rst_valid", stream_valid, 0);
    check("rst_last", stream_last, 0);
    check("rst_done", stream_done, 0);
    check("rst_blocked", wr_blocked, 0);
    check("rst_sbuf", stream_buf, 0);
    reset = 1'b0;
    tick();

    // ---- 1: core write/read, no bypass ----
    bufp = 3'd2; fieldp = 5'd7; fieldwp = 5'd7; field_wdata = 8'hA5; field_wr_en = 1'b1;
    #1;
    check("no_bypass", field_rdata, 8'h00);
    tick();
    field_wr_en = 1'b0;
    #1;
    check("read_2_7", field_rdata, 8'hA5);
    fieldp = 5'd6; #1;
    check("read_2_6", field_rdata, 8'h00);
    bufp = 3'd1; fieldp = 5'd7; #1;
    check("read_1_7", field_rdata, 8'h00);

    // ---- 2: full-rate stream of buffer 3 ----
    fill(3'd3, 8'h00);
    stream_check(3'd3, 8'h00, 1'b0, 1'b0, 1'b1);

    // ---- 6: buffer contents after streaming, then re-commit ----
    for (int i = 0; i < 32; i += 5) begin
      bufp = 3'd3; fieldp = 5'(i); #1;
      check($sformatf("post_stream_3_%0d", i), field_rdata, AUTOCLEAR ? 8'h00 : 8'(i));
    end
    stream_check(3'd3, 8'h00, AUTOCLEAR, 1'b0, 1'b1);

    // ---- 3: stalled stream of buffer 5 ----
    fill(3'd5, 8'h40);
    stream_check(3'd5, 8'h40, 1'b0, 1'b1, 1'b1);

    // ---- 4: blocked write, unblocked write, ignored commit ----
    fill(3'd3, 8'h10);
    bufp = 3'd3; commit = 1'b1; stream_ready = 1'b0;
    tick();
    commit = 1'b0;
    check("busy_started", busy, 1);
    write_word(3'd3, 5'd0, 8'h77);
    check("blocked_pulse", wr_blocked, 1);
    bufp = 3'd4; fieldwp = 5'd0; field_wdata = 8'h66; field_wr_en = 1'b1; commit = 1'b1;
    tick();
    field_wr_en = 1'b0; commit = 1'b0;
    check("unblocked_no_pulse", wr_blocked, 0);
    check("commit_ignored_buf", stream_buf, 3);
    check("held_data", stream_data, 8'h10);
    bufp = 3'd3; fieldp = 5'd0; #1;
    check("read_3_0_kept", field_rdata, 8'h10);
    bufp = 3'd4; #1;
    check("read_4_0_written", field_rdata, 8'h66);
    stream_check(3'd3, 8'h10, 1'b0, 1'b0, 1'b0);

    // ---- 5: reset mid-stream ----
    fill(3'd6, 8'h80);
    bufp = 3'd6; commit = 1'b1; stream_ready = 1'b1;
    tick();
    commit = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    check("beat10_data", stream_data, 8'h8A);
    reset = 1'b1;
    fieldp = 5'd3; #1;
    check("abort_valid", stream_valid, 0);
    check("abort_busy", busy, 0);
    check("abort_read", field_rdata, 8'h00);
    tick();
    reset = 1'b0;
    stream_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("abort_no_done_%0d", i), stream_done, 0);
      tick();
    end
    bufp = 3'd2; fieldp = 5'd7; #1;
    check("abort_mem_cleared", field_rdata, 8'h00);
    check("abort_sbuf", stream_buf, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // hard time limit so the run always ends
  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
